// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter: PORT_NUM valid/ready requesters share one registered
// DATA_WIDTH output stage through a one-hot AND-OR mux.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   req_valid_i  per-port request valid
//   req_data_i   per-port data, port k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   req_ready_o  per-port accept, at most one bit high
//   out_valid_o  output stage holds a word
//   out_ready_i  downstream accepts the word
//   out_data_o   registered output word
//   grant_o      registered one-hot source of out_data_o, zero when empty
//   busy_o       any request pending or output word held
//   req_last_i   (only with RR_ARB_LOCK_EN) marks the last word of a packet
//
// Optional feature macro: RR_ARB_LOCK_EN (packet lock until req_last_i).
module rr_mux_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int PORT_NUM   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [PORT_NUM-1:0]            req_valid_i,
    input  logic [DATA_WIDTH*PORT_NUM-1:0] req_data_i,
`ifdef RR_ARB_LOCK_EN
    input  logic [PORT_NUM-1:0]            req_last_i,
`endif
    output logic [PORT_NUM-1:0]            req_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [PORT_NUM-1:0]            grant_o,
    output logic                           busy_o
);

    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PW-1:0]         r_ptr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [PORT_NUM-1:0]   r_grant;
`ifdef RR_ARB_LOCK_EN
    logic                  r_lock;
    logic [PW-1:0]         r_lock_port;
`endif

    logic [PORT_NUM-1:0]   w_win;
    logic [PW-1:0]         w_win_idx;
    logic                  w_found;
    logic [PW:0]           w_idx;
    logic                  w_free;
    logic                  w_xfer;
    logic [PW-1:0]         w_ptr_next;
    logic [DATA_WIDTH-1:0] w_mux;
    logic [PORT_NUM-1:0]   w_ready;

    // Rotating priority search: first valid port at or after the pointer.
    always_comb begin
        w_win     = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(PORT_NUM))
                w_idx = w_idx - (PW+1)'(PORT_NUM);
            if (!w_found && req_valid_i[w_idx[PW-1:0]]) begin
                w_found                = 1'b1;
                w_win_idx              = w_idx[PW-1:0];
                w_win[w_idx[PW-1:0]]   = 1'b1;
            end
        end
`ifdef RR_ARB_LOCK_EN
        // A locked packet owner is the only candidate, even while idle.
        if (r_lock) begin
            w_win              = '0;
            w_win_idx          = r_lock_port;
            w_found            = req_valid_i[r_lock_port];
            w_win[r_lock_port] = req_valid_i[r_lock_port];
        end
`endif
    end

    // One-hot AND-OR data mux.
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < PORT_NUM; k++)
            w_mux = w_mux | (req_data_i[k*DATA_WIDTH +: DATA_WIDTH]
                             & {DATA_WIDTH{w_win[k]}});
    end

    // Free when empty or draining this cycle; gated low while in reset.
    assign w_free     = (~r_valid | out_ready_i) & rst_n_i;
    assign w_ready    = w_win & {PORT_NUM{w_free}};
    assign w_xfer     = w_found & w_free;
    assign w_ptr_next = (w_win_idx == PW'(PORT_NUM-1)) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr       <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_grant     <= '0;
`ifdef RR_ARB_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_port <= '0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_mux;
            r_grant <= w_win;
`ifdef RR_ARB_LOCK_EN
            if (req_last_i[w_win_idx]) begin
                r_lock <= 1'b0;
                r_ptr  <= w_ptr_next;
            end else begin
                r_lock      <= 1'b1;
                r_lock_port <= w_win_idx;
            end
`else
            r_ptr   <= w_ptr_next;
`endif
        end else if (r_valid && out_ready_i) begin
            r_valid <= 1'b0;
            r_grant <= '0;
        end
    end

    assign req_ready_o = w_ready;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign grant_o     = r_grant;
    assign busy_o      = (|req_valid_i) | r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table, directed corner
// sequences and constrained-random traffic against a behavioural model.
module tb_rr_mux_arbiter;

    localparam int DW = 8;
    localparam int P  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [P-1:0]  req_valid = '0;
    logic [DW*P-1:0] req_data = '0;
    logic [P-1:0]  req_last = '0;
    logic [P-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [P-1:0]  grant;
    logic          busy;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.DATA_WIDTH(DW), .PORT_NUM(P)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef RR_ARB_LOCK_EN
        .req_last_i  (req_last),
`endif
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_ptr;
    bit          m_lock;
    int          m_lport;
    bit          m_ov;
    logic [7:0]  m_od;
    logic [3:0]  m_gnt;

    // Contract monitor state (random phase only)
    bit          mon_en = 1'b0;
    logic [3:0]  prev_pend = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic int m_winner(input logic [3:0] v);
        if (m_lock) return v[m_lport] ? m_lport : -1;
        for (int i = 0; i < P; i++)
            if (v[(m_ptr + i) % P]) return (m_ptr + i) % P;
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_lock = 0; m_lport = 0;
        m_ov = 0; m_od = '0; m_gnt = '0;
        prev_pend = '0;
    endtask

    // One cycle: drive at negedge, check accept path, then check registers.
    task automatic step(input logic [3:0] v, input logic [31:0] d,
                        input logic o, input logic [3:0] last);
        int w;
        bit free;
        logic [3:0] exp_rdy;
        @(negedge clk);
        req_valid = v; req_data = d; out_ready = o; req_last = last;
        #1;
        w = m_winner(v);
        free = !m_ov || o;
        exp_rdy = (w >= 0 && free) ? 4'(1 << w) : 4'b0;
        chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
        chk("busy_pre", {31'b0, busy}, {31'b0, (|v) | m_ov});
        if (mon_en)
            for (int k = 0; k < P; k++)
                if (prev_pend[k])
                    chk("contract_hold", {31'b0, v[k]}, 32'd1);
        prev_pend = v & ~exp_rdy;
        @(posedge clk);
        if (exp_rdy != 0) begin
            m_ov = 1; m_od = d[w*DW +: DW]; m_gnt = exp_rdy;
`ifdef RR_ARB_LOCK_EN
            if (last[w]) begin m_lock = 0; m_ptr = (w + 1) % P; end
            else begin m_lock = 1; m_lport = w; end
`else
            m_ptr = (w + 1) % P;
`endif
        end else if (m_ov && o) begin
            m_ov = 0; m_gnt = '0;
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_data", {24'b0, out_data}, {24'b0, m_od});
        chk("grant", {28'b0, grant}, {28'b0, m_gnt});
        chk("busy_post", {31'b0, busy}, {31'b0, (|v) | m_ov});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {24'b0, out_data}, 32'd0);
        chk("rst_grant", {28'b0, grant}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [3:0] v;
        logic       o;
        logic [3:0] rdy;
        logic       ov;
        logic [3:0] gnt;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[9];
    localparam logic [31:0] DA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    logic [3:0]  pend;
    logic [31:0] rd;
    logic [3:0]  rv;

    initial begin
        m_reset();
        // Continuous all-port request, then ports 0 and 2 only.
        tbl[0] = '{4'hF, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA0};
        tbl[1] = '{4'hF, 1'b1, 4'h2, 1'b1, 4'h2, 8'hA1};
        tbl[2] = '{4'hF, 1'b1, 4'h4, 1'b1, 4'h4, 8'hA2};
        tbl[3] = '{4'hF, 1'b1, 4'h8, 1'b1, 4'h8, 8'hA3};
        tbl[4] = '{4'hF, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA0};
        tbl[5] = '{4'h5, 1'b1, 4'h4, 1'b1, 4'h4, 8'hA2};
        tbl[6] = '{4'h5, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA0};
        tbl[7] = '{4'h5, 1'b1, 4'h4, 1'b1, 4'h4, 8'hA2};
        tbl[8] = '{4'h5, 1'b1, 4'h1, 1'b1, 4'h1, 8'hA0};

        #1;
        chk("rst_ready", {28'b0, req_ready}, 32'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = tbl[i].v; req_data = DA;
            out_ready = tbl[i].o; req_last = '1;
            #1;
            chk("tbl_ready", {28'b0, req_ready}, {28'b0, tbl[i].rdy});
            @(posedge clk); #1;
            chk("tbl_valid", {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk("tbl_grant", {28'b0, grant}, {28'b0, tbl[i].gnt});
            chk("tbl_data", {24'b0, out_data}, {24'b0, tbl[i].dat});
        end

        // Stall with a word from port 1 held.
        do_reset();
        step(4'h2, DA, 1'b1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, DA, 1'b0, 4'hF);
            chk("stall_ready", {28'b0, req_ready}, 32'd0);
            chk("stall_grant", {28'b0, grant}, 32'h2);
            chk("stall_data", {24'b0, out_data}, 32'hA1);
        end
        step(4'hF, DA, 1'b1, 4'hF);
        chk("after_stall", {28'b0, grant}, 32'h4);

        // Single word from port 3, drain, pointer wraps to 0.
        do_reset();
        step(4'h8, DA, 1'b1, 4'hF);
        chk("single_grant", {28'b0, grant}, 32'h8);
        step(4'h0, DA, 1'b1, 4'hF);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_grant", {28'b0, grant}, 32'd0);
        chk("drain_busy", {31'b0, busy}, 32'd0);
        chk("drain_data", {24'b0, out_data}, 32'hA3);
        step(4'hF, DA, 1'b1, 4'hF);
        chk("wrap_grant", {28'b0, grant}, 32'h1);

        // Asynchronous reset mid-stream.
        step(4'hF, DA, 1'b1, 4'hF);
        step(4'hF, DA, 1'b1, 4'hF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_grant", {28'b0, grant}, 32'd0);
        chk("arst_data", {24'b0, out_data}, 32'd0);
        chk("arst_ready", {28'b0, req_ready}, 32'd0);
        req_valid = '0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'hF, DA, 1'b1, 4'hF);
        chk("arst_first", {28'b0, grant}, 32'h1);

`ifdef RR_ARB_LOCK_EN
        // Port 1 three-word packet while port 0 keeps requesting.
        do_reset();
        step(4'h1, DA, 1'b1, 4'hF);
        step(4'h3, DA, 1'b1, 4'h0);
        chk("lock_w1", {28'b0, grant}, 32'h2);
        step(4'h1, DA, 1'b1, 4'h0);
        chk("lock_idle", {28'b0, req_ready}, 32'd0);
        step(4'h3, DA, 1'b1, 4'h0);
        chk("lock_w2", {28'b0, grant}, 32'h2);
        step(4'h3, DA, 1'b1, 4'h2);
        chk("lock_w3", {28'b0, grant}, 32'h2);
        step(4'h1, DA, 1'b1, 4'hF);
        chk("lock_after", {28'b0, grant}, 32'h1);
`endif

        // Random traffic; pending requests hold valid and data.
        do_reset();
        mon_en = 1'b1;
        pend = '0;
        rd = $urandom;
        for (int c = 0; c < 600; c++) begin
            rv = pend;
            for (int k = 0; k < P; k++)
                if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
                    rv[k] = 1'b1;
                    rd[k*DW +: DW] = 8'($urandom);
                end
            step(rv, rd, ($urandom_range(0, 3) != 0), 4'($urandom));
            pend = prev_pend;
        end
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one DATA_WIDTH output channel between PORT_NUM valid/ready requesters.
- Selects one requester per transfer and steers its data through the existing one-hot mux block (mux, ctrl_i = one-hot grant).
- Captures the selected data into a single-entry registered output stage.
- Sits in front of any shared downstream sink (bus, FIFO, serializer) that needs fair multi-source access.

Parameters:
- DATA_WIDTH, 8, width of each requester's data word.
- PORT_NUM, 4, number of requesters; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  PORT_NUM  per-port request valid.
- req_data_i  input  DATA_WIDTH*PORT_NUM  per-port data; port k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- req_ready_o  output  PORT_NUM  per-port accept; at most one bit high per cycle.
- out_valid_o  output  1  output stage holds a word.
- out_ready_i  input  1  downstream accepts the word.
- out_data_o  output  DATA_WIDTH  registered output word.
- grant_o  output  PORT_NUM  registered one-hot source of the word in out_data_o; all zero when empty.
- busy_o  output  1  OR of req_valid_i and out_valid_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - out_valid_o=0, out_data_o=0, grant_o=0.
  - Round-robin pointer = port 0 (highest priority).
  - req_ready_o=0 while in reset.
- Stage free: free = ~out_valid_o | out_ready_i. This allows a same-cycle drain and refill.
- Arbitration (combinational):
  - Search req_valid_i starting at the pointer, wrapping PORT_NUM-1 -> 0.
  - The first set bit is the winner; win = one-hot vector.
  - req_ready_o = win & {PORT_NUM{free}}. This is a combinational path from out_ready_i to req_ready_o; this path is accepted.
- Transfer on requester k: req_valid_i[k] & req_ready_o[k]. On the next edge:
  - out_data_o <= mux output for port k.
  - out_valid_o <= 1.
  - grant_o <= win.
  - Pointer <= k+1 mod PORT_NUM.
- Downstream drain: out_valid_o & out_ready_i.
  - Without a simultaneous transfer: out_valid_o <= 0, grant_o <= 0. out_data_o holds its last value.
  - With a simultaneous transfer: the new word loads; no bubble.
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 word/cycle with out_ready_i held high.
- Stall: out_valid_o=1 and out_ready_i=0 -> all req_ready_o=0. out_data_o and grant_o stable. Pointer unchanged.
- Fairness: under continuous all-port request, grant order is 0,1,...,PORT_NUM-1,0,...
  - A port that deasserts is skipped with no idle cycle.
  - Worst-case wait is PORT_NUM-1 transfers.
- No request: all req_ready_o=0, pointer unchanged.
- Requester contract: req_valid_i must not drop before acceptance. The arbiter itself is not required to tolerate a drop. The bench flags a violation.
- Reset mid-operation: the word in the output stage is discarded, and all state returns to reset values immediately.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input req_last_i, width PORT_NUM.
  - Once port k transfers with req_last_i[k]=0, the arbiter locks to k. Only port k can be granted until it transfers with req_last_i[k]=1.
  - Other ports wait even if k is momentarily idle.
  - The pointer advances only on the last transfer.
  - Reset clears the lock.
- Undefined: no req_last_i port. Re-arbitration happens on every transfer, as above.

Test Plan:
- Reset, then req_valid_i=4'b1111, out_ready_i=1, data port k = 8'hA0+k -> grant_o sequence 0001,0010,0100,1000,0001. out_data_o A0,A1,A2,A3,A0 on consecutive cycles; out_valid_o continuously 1 from cycle 1.
- req_valid_i=4'b0101, out_ready_i=1 -> grants alternate port 0, port 2, port 0. Ports 1 and 3 req_ready_o never high.
- Port 1 accepted, then out_ready_i=0 for 5 cycles with all ports requesting -> out_data_o and grant_o=0010 held. req_ready_o=0. After release, next grant is port 2.
- Single word from port 3, then req_valid_i=0 -> out_valid_o high one cycle then 0, grant_o returns to 0, busy_o falls. Pointer is 0, so the next all-port request goes to port 0.
- Assert rst_n_i low mid-stream while out_valid_o=1 -> out_valid_o, grant_o, out_data_o immediately 0 (no clock edge needed). After release, first grant is port 0.
- RR_ARB_LOCK_EN defined: port 1 sends 3 words (last on word 3) while port 0 requests -> outputs 1,1,1 then port 2/0 per pointer. Port 0 is not granted mid-packet.
